// File: rtl/icache_assoc.sv
// Set-associative instruction cache between IF and MemCtrl: zero-latency hits,
// burst refill of a whole line per miss, round-robin replacement and flush.
module icache_assoc #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_valid_o,
  output logic [31:0]       if_inst_o,
  output logic              mc_req_o,
  output logic [ADDR_W-1:0] mc_addr_o,
  input  logic              mc_valid_i,
  input  logic [31:0]       mc_data_i
);

  localparam int unsigned SETS  = 1 << INDEX_BITS;
  localparam int unsigned WB    = $clog2(LINE_WORDS);
  localparam int unsigned CNT_W = (WB > 0) ? WB : 1;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned TAG_W = ADDR_W - 2 - WB - INDEX_BITS;

  typedef enum logic {IDLE, REFILL} state_e;

  logic                  valid_q [SETS][WAYS];
  logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
  logic [31:0]           data_q  [SETS][WAYS][LINE_WORDS];
  logic [WAY_W-1:0]      ptr_q   [SETS];

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic [TAG_W-1:0]      mtag_q, mtag_d;
  logic [WAY_W-1:0]      victim_q, victim_d;
  logic                  drop_q, drop_d;
  logic                  mc_req_q, mc_req_d;
  logic [ADDR_W-1:0]     mc_addr_q, mc_addr_d;

  logic [CNT_W-1:0]      req_off;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [ADDR_W-1:0]     line_base;
  logic                  hit_c;
  logic [WAY_W-1:0]      hit_way_c;
  logic [WAY_W-1:0]      victim_c;
  logic                  word_we_c;
  logic                  install_c;
  logic                  ptr_adv_c;

  assign req_off   = CNT_W'((if_addr_i >> 2) & ADDR_W'(LINE_WORDS - 1));
  assign req_idx   = INDEX_BITS'(if_addr_i >> (2 + WB));
  assign req_tag   = TAG_W'(if_addr_i >> (2 + WB + INDEX_BITS));
  assign line_base = if_addr_i & ~ADDR_W'(LINE_WORDS * 4 - 1);

  // Tag lookup and victim choice; descending scan lets the lowest invalid way win.
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    victim_c  = ptr_q[req_idx];
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) victim_c = WAY_W'(w);
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
    end
  end

  assign if_valid_o = rdy && (state_q == IDLE) && if_req_i && hit_c;
  assign if_inst_o  = if_valid_o ? data_q[req_idx][hit_way_c][req_off] : 32'd0;
  assign mc_req_o   = mc_req_q;
  assign mc_addr_o  = mc_addr_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    mtag_d    = mtag_q;
    victim_d  = victim_q;
    drop_d    = drop_q;
    mc_req_d  = mc_req_q;
    mc_addr_d = mc_addr_q;
    word_we_c = 1'b0;
    install_c = 1'b0;
    ptr_adv_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req_i && !hit_c) begin
          state_d   = REFILL;
          cnt_d     = '0;
          idx_d     = req_idx;
          mtag_d    = req_tag;
          victim_d  = victim_c;
          mc_req_d  = 1'b1;
          mc_addr_d = line_base;
        end
      end
      REFILL: begin
        if (flush_i) drop_d = 1'b1;
        if (mc_valid_i) begin
          word_we_c = 1'b1;
          if (cnt_q != CNT_W'(LINE_WORDS - 1)) begin
            cnt_d     = cnt_q + 1'b1;
            mc_addr_d = mc_addr_q + ADDR_W'(4);
          end else begin
            // A flush seen during the burst (including this cycle) discards the line.
            install_c = !drop_q && !flush_i;
            ptr_adv_c = (victim_q == ptr_q[idx_q]);
            state_d   = IDLE;
            cnt_d     = '0;
            drop_d    = 1'b0;
            mc_req_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      mtag_q    <= '0;
      victim_q  <= '0;
      drop_q    <= 1'b0;
      mc_req_q  <= 1'b0;
      mc_addr_q <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        ptr_q[s] <= '0;
        for (int w = 0; w < int'(WAYS); w++) valid_q[s][w] <= 1'b0;
      end
    end else if (rdy) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      mtag_q    <= mtag_d;
      victim_q  <= victim_d;
      drop_q    <= drop_d;
      mc_req_q  <= mc_req_d;
      mc_addr_q <= mc_addr_d;
      if (flush_i) begin
        for (int s = 0; s < int'(SETS); s++)
          for (int w = 0; w < int'(WAYS); w++) valid_q[s][w] <= 1'b0;
      end
      if (install_c) valid_q[idx_q][victim_q] <= 1'b1;
      if (ptr_adv_c) ptr_q[idx_q] <= (WAYS > 1) ? ptr_q[idx_q] + 1'b1 : '0;
    end
  end

  // Payload arrays carry no reset; valid bits gate every read.
  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      if (word_we_c) data_q[idx_q][victim_q][cnt_q] <= mc_data_i;
      if (install_c) tag_q[idx_q][victim_q] <= mtag_q;
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: a line-level cache model checked every cycle,
// plus literal expectations for burst addresses, hit data and reset values.
module tb_icache_assoc;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_valid;
  logic [31:0] mc_data;

  icache_assoc dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .flush_i    (flush),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_valid_o (if_valid),
    .if_inst_o  (if_inst),
    .mc_req_o   (mc_req),
    .mc_addr_o  (mc_addr),
    .mc_valid_i (mc_valid),
    .mc_data_i  (mc_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: 64 sets x 2 ways of 4-word lines, with each set's round-robin pointer.
  bit          m_valid [64][2];
  int unsigned m_tag   [64][2];
  logic [31:0] m_data  [64][2][4];
  int          m_ptr   [64];
  bit          busy, m_drop;
  int          b_set, b_way, b_n;
  int unsigned b_tag;
  logic [31:0] b_base;

  function automatic int set_of(input logic [31:0] a); return int'((a >> 4) & 32'h3F); endfunction
  function automatic int unsigned tag_of(input logic [31:0] a); return a >> 10; endfunction
  function automatic int off_of(input logic [31:0] a); return int'((a >> 2) & 32'h3); endfunction

  function automatic bit lookup(input logic [31:0] a, output int way);
    way = 0;
    for (int w = 0; w < 2; w++)
      if (m_valid[set_of(a)][w] && m_tag[set_of(a)][w] == tag_of(a)) begin
        way = w;
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic void clear_valid();
    for (int s = 0; s < 64; s++) begin
      m_valid[s][0] = 1'b0;
      m_valid[s][1] = 1'b0;
    end
  endfunction

  always @(posedge clk) begin
    int w;
    if (rst) begin
      clear_valid();
      for (int s = 0; s < 64; s++) m_ptr[s] = 0;
      busy   = 1'b0;
      m_drop = 1'b0;
    end else if (rdy) begin
      if (!busy) begin
        if (if_req && !lookup(if_addr, w)) begin
          busy   = 1'b1;
          b_set  = set_of(if_addr);
          b_tag  = tag_of(if_addr);
          b_base = if_addr & ~32'hF;
          b_n    = 0;
          if (!m_valid[b_set][0]) b_way = 0;
          else if (!m_valid[b_set][1]) b_way = 1;
          else b_way = m_ptr[b_set];
        end
      end else begin
        if (flush) m_drop = 1'b1;
        if (mc_valid) begin
          m_data[b_set][b_way][b_n] = mc_data;
          if (b_n == 3) begin
            if (!m_drop) begin
              m_valid[b_set][b_way] = 1'b1;
              m_tag[b_set][b_way]   = b_tag;
            end
            if (b_way == m_ptr[b_set]) m_ptr[b_set] = (m_ptr[b_set] + 1) % 2;
            busy   = 1'b0;
            m_drop = 1'b0;
          end else begin
            b_n++;
          end
        end
      end
      if (flush) clear_valid();
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    int          w;
    bit          h;
    logic        ev;
    logic [31:0] ei;
    if (cmp_en) begin
      h  = lookup(if_addr, w);
      ev = rdy && !busy && if_req && h;
      ei = ev ? m_data[set_of(if_addr)][w][off_of(if_addr)] : 32'd0;
      chk("model_if_valid", {31'd0, if_valid}, {31'd0, ev});
      chk("model_if_inst", if_inst, ei);
      chk("model_mc_req", {31'd0, mc_req}, {31'd0, busy});
      if (busy) chk("model_mc_addr", mc_addr, b_base + 32'(4 * b_n));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Acts as MemCtrl for one 4-word burst, optionally flushing or stalling at word k.
  task automatic serve(input logic [31:0] a, input logic [31:0] dbase, input int flush_k, input int stall_k);
    for (int k = 0; k < 4; k++) begin
      if (k == flush_k) flush = 1'b1;
      tick();
      flush = 1'b0;
      if (k == stall_k) begin
        rdy = 1'b0;
        repeat (5) begin
          tick();
          chk("stall_addr", mc_addr, a + 32'(4 * k));
          chk("stall_req", {31'd0, mc_req}, 32'd1);
          chk("stall_if_valid", {31'd0, if_valid}, 32'd0);
        end
        rdy = 1'b1;
      end
      chk("burst_addr", mc_addr, a + 32'(4 * k));
      chk("burst_req", {31'd0, mc_req}, 32'd1);
      mc_valid = 1'b1;
      mc_data  = dbase + 32'(k);
      tick();
      mc_valid = 1'b0;
    end
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] dbase, input int flush_k, input int stall_k);
    if_req  = 1'b1;
    if_addr = a;
    #1;
    chk("fill_first_miss", {31'd0, if_valid}, 32'd0);
    tick();
    serve(a, dbase, flush_k, stall_k);
    if (flush_k < 0) begin
      chk("fill_then_hit", {31'd0, if_valid}, 32'd1);
      chk("fill_then_inst", if_inst, dbase + 32'(off_of(a)));
    end else begin
      chk("dropped_line_miss", {31'd0, if_valid}, 32'd0);
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic probe_hit(input logic [31:0] a, input logic [31:0] exp_inst);
    if_req  = 1'b1;
    if_addr = a;
    #1;
    chk("hit_valid", {31'd0, if_valid}, 32'd1);
    chk("hit_inst", if_inst, exp_inst);
    chk("hit_no_req", {31'd0, mc_req}, 32'd0);
    tick();
    if_req = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_mc_req", {31'd0, mc_req}, 32'd0);
    chk("rst_mc_addr", mc_addr, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; if_req = 1'b0; if_addr = '0;
    mc_valid = 1'b0; mc_data = '0;
    repeat (3) tick();
    check_reset_outputs();
    rst = 1'b0;
    cmp_en = 1'b1;
    tick();

    // Cold miss, hit, and round-robin replacement in set 0.
    fill(32'h1000, 32'hA0, -1, -1);
    probe_hit(32'h1008, 32'hA2);
    fill(32'h1400, 32'hB0, -1, -1);
    fill(32'h1800, 32'hC0, -1, -1);
    probe_hit(32'h1404, 32'hB1);
    probe_hit(32'h1808, 32'hC2);
    fill(32'h1C00, 32'hD0, -1, -1);
    probe_hit(32'h1800, 32'hC0);
    probe_hit(32'h1C04, 32'hD1);
    fill(32'h1000, 32'hE0, -1, -1);
    probe_hit(32'h1C00, 32'hD0);
    fill(32'h1800, 32'hF0, -1, -1);
    probe_hit(32'h100C, 32'hE3);

    // Flush during word 2 of a refill.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    fill(32'h1400, 32'h40, -1, -1);
    fill(32'h1000, 32'h50, 2, -1);
    fill(32'h1000, 32'h60, -1, -1);
    fill(32'h1400, 32'h70, -1, -1);

    // rdy stall mid-burst at 0x2004.
    fill(32'h2000, 32'h80, -1, 1);

    // Spurious MemCtrl pulse while idle changes nothing.
    mc_valid = 1'b1;
    mc_data  = 32'hDEAD;
    tick();
    mc_valid = 1'b0;
    tick();
    probe_hit(32'h2000, 32'h80);
    probe_hit(32'h2004, 32'h81);
    fill(32'h2400, 32'h90, -1, -1);

    // Reset during a refill aborts it.
    if_req  = 1'b1;
    if_addr = 32'h3000;
    tick();
    tick();
    mc_valid = 1'b1;
    mc_data  = 32'h11;
    tick();
    mc_valid = 1'b0;
    rst = 1'b1;
    tick();
    check_reset_outputs();
    rst    = 1'b0;
    if_req = 1'b0;
    tick();
    fill(32'h3000, 32'h30, -1, -1);
    probe_hit(32'h3008, 32'h32);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
